// File: rtl/sliding_window_buf_if.sv
// Pixel-stream interface for sliding_window_buf.
// master: pixel source / window consumer side; slave: the window generator.
interface sliding_window_buf_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3
) ();
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic [DATA_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_sof;
  logic [K*K*DATA_W-1:0] out_win;
  logic                  out_valid;
  logic [ROW_W-1:0]      out_row;
  logic [COL_W-1:0]      out_col;
  logic                  frame_done;

  modport master (
    output in_data, in_valid, in_sof,
    input  out_win, out_valid, out_row, out_col, frame_done
  );

  modport slave (
    input  in_data, in_valid, in_sof,
    output out_win, out_valid, out_row, out_col, frame_done
  );
endinterface

// File: rtl/sliding_window_buf.sv
// K x K sliding-window generator for raster pixel streams.
// K-1 cascaded line memories feed the right-hand column of a K x K register
// window; every accepted pixel produces one window one cycle later, tagged
// with the row/column of its bottom-right pixel.
// Optional build macro SLIDING_WIN_ZPAD_EN: every pixel yields a window and
// taps that fall above row 0 or left of column 0 read as zero.
module sliding_window_buf #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3
) (
  input logic              clk,
  input logic              rst_n,
  sliding_window_buf_if.slave bus
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  logic              accept;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [COL_W-1:0]  nxt_col;
  logic [ROW_W-1:0]  nxt_row;

  logic [DATA_W-1:0] line_mem [K-1][IMG_W];
  logic [DATA_W-1:0] new_col  [K];
  logic [DATA_W-1:0] win      [K][K];

  logic              win_valid;
  logic              done_pulse;
  logic [ROW_W-1:0]  row_tag;
  logic [COL_W-1:0]  col_tag;
  logic [K*K*DATA_W-1:0] win_flat;

`ifdef SLIDING_WIN_ZPAD_EN
  logic [K-1:0] row_keep_nxt;
  logic [K-1:0] col_keep_nxt;
  logic [K-1:0] row_keep;
  logic [K-1:0] col_keep;
`else
  logic         interior;
`endif

  // Position of the pixel being accepted (sof forces (0,0)) and where the raster goes next.
  always_comb begin
    accept  = bus.in_valid;
    cur_col = col;
    cur_row = row;
    nxt_col = col;
    nxt_row = row;
    if (bus.in_sof) begin
      cur_col = '0;
      cur_row = '0;
    end else begin
      cur_col = col;
      cur_row = row;
    end
    if (cur_col == COL_LAST) begin
      nxt_col = '0;
      if (cur_row == ROW_LAST) begin
        nxt_row = '0;
      end else begin
        nxt_row = cur_row + ROW_W'(1);
      end
    end else begin
      nxt_col = cur_col + COL_W'(1);
      nxt_row = cur_row;
    end
  end

  // Raster row/column counters advance once per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= nxt_col;
      row <= nxt_row;
    end else begin
      col <= col;
      row <= row;
    end
  end

  // Line memory cascade: memory 0 takes the new pixel, memory m takes m-1's old entry.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[0][cur_col] <= bus.in_data;
      for (int m = 1; m < K - 1; m++) begin
        line_mem[m][cur_col] <= line_mem[m-1][cur_col];
      end
    end
  end

  // New right-hand window column: oldest line memory on top, live pixel at the bottom.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      new_col[i] = '0;
    end
    for (int i = 0; i < K - 1; i++) begin
      new_col[i] = line_mem[K-2-i][cur_col];
    end
    new_col[K-1] = bus.in_data;
  end

  // Window registers shift left one tap per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win[i][j] <= win[i][j+1];
        end
        win[i][K-1] <= new_col[i];
      end
    end else begin
      win <= win;
    end
  end

`ifdef SLIDING_WIN_ZPAD_EN
  // Which window rows/columns lie inside the frame for the accepted pixel.
  always_comb begin
    row_keep_nxt = '0;
    col_keep_nxt = '0;
    for (int i = 0; i < K; i++) begin
      row_keep_nxt[i] = (int'(cur_row) + i) >= (K - 1);
      col_keep_nxt[i] = (int'(cur_col) + i) >= (K - 1);
    end
  end

  // Registered zero-pad mask, aligned with the window registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_keep <= '0;
      col_keep <= '0;
    end else if (accept) begin
      row_keep <= row_keep_nxt;
      col_keep <= col_keep_nxt;
    end else begin
      row_keep <= row_keep;
      col_keep <= col_keep;
    end
  end
`else
  // Only windows fully inside the frame are flagged valid.
  always_comb begin
    interior = (cur_row >= ROW_W'(K - 1)) && (cur_col >= COL_W'(K - 1));
  end
`endif

  // Output qualifiers and position tags, one cycle after the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      done_pulse <= 1'b0;
      row_tag    <= '0;
      col_tag    <= '0;
    end else if (accept) begin
`ifdef SLIDING_WIN_ZPAD_EN
      win_valid  <= 1'b1;
`else
      win_valid  <= interior;
`endif
      done_pulse <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      row_tag    <= cur_row;
      col_tag    <= cur_col;
    end else begin
      win_valid  <= 1'b0;
      done_pulse <= 1'b0;
      row_tag    <= row_tag;
      col_tag    <= col_tag;
    end
  end

  // Flatten the window; tap (i,j) sits at slice (i*K+j).
  always_comb begin
    win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
`ifdef SLIDING_WIN_ZPAD_EN
        if (row_keep[i] && col_keep[j]) begin
          win_flat[(i*K+j)*DATA_W +: DATA_W] = win[i][j];
        end else begin
          win_flat[(i*K+j)*DATA_W +: DATA_W] = '0;
        end
`else
        win_flat[(i*K+j)*DATA_W +: DATA_W] = win[i][j];
`endif
      end
    end
  end

  assign bus.out_win    = win_flat;
  assign bus.out_valid  = win_valid;
  assign bus.frame_done = done_pulse;
  assign bus.out_row    = row_tag;
  assign bus.out_col    = col_tag;
endmodule

// File: doc/sliding_window_buf.md
Name: sliding_window_buf

Overview:
Parametrised K x K sliding-window generator for streaming raster images, generalising the 3-row line buffer in data width, kernel size and image height. Holds K-1 line memories plus a K x K register window. Emits the full window each accepted pixel, with row/column tags, a window-valid qualifier and an end-of-frame pulse. Sits between the pixel source and the convolution/pooling MAC arrays.

Parameters:
DATA_W, 8, pixel bit width
IMG_W, 28, pixels per row (>= K)
IMG_H, 28, rows per frame (>= K)
K, 3, window size (>= 2)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_data  input  DATA_W  pixel in raster order
in_valid  input  1  pixel accepted this cycle when high (no backpressure)
in_sof  input  1  start of frame; sampled only with in_valid; this pixel becomes (0,0)
out_win  output  K*K*DATA_W  window; tap (i,j) at bits [(i*K+j)*DATA_W +: DATA_W] = pixel(r-K+1+i, c-K+1+j)
out_valid  output  1  out_win is a valid window
out_row  output  clog2(IMG_H)  row r of window's bottom-right pixel
out_col  output  clog2(IMG_W)  column c of window's bottom-right pixel
frame_done  output  1  one-cycle pulse with the window of pixel (IMG_H-1, IMG_W-1)

Behaviour:
- Reset: out_win, out_valid, out_row, out_col, frame_done = 0; row/col counters = 0. Line memories not reset.
- Reset mid-frame: outputs clear immediately; next accepted pixel is (0,0).
- Counters: col increments per accepted pixel; IMG_W-1 wraps to 0 and increments row; row IMG_H-1 with col wrap returns to 0. in_sof overrides: pixel tagged (0,0), counters continue from there.
- Line memories: K-1 rows of IMG_W entries. On accept at column c, memory 0 takes in_data; memory m takes memory m-1's old entry at c (cascade, same as 3-row generation).
- Window: on accept, each window row shifts left one tap; new right column = {mem K-2 .. mem 0 at c, in_data}, top to bottom.
- Latency: 1 cycle. Pixel accepted at cycle t -> out_win/out_row/out_col/out_valid/frame_done updated at t+1.
- out_valid (macro off): high at t+1 only if accepted pixel has r >= K-1 and c >= K-1; else 0. Windows per frame: (IMG_H-K+1)*(IMG_W-K+1).
- in_valid low: out_valid and frame_done drop next cycle; out_win, out_row, out_col, counters, memories hold.
- Column wrap: window taps left of column 0 hold stale previous-row pixels; masked by out_valid (or zeroed, macro on).
- Back-to-back frames: no idle cycles required; frame N+1 windows contain only frame N+1 data wherever out_valid is high.
- frame_done ignores out_valid gating; pulses even if K > position rules would suppress it (always valid since IMG_H,IMG_W >= K).

Optional Feature:
SLIDING_WIN_ZPAD_EN
- Defined: out_valid high one cycle after every accepted pixel (IMG_W*IMG_H windows/frame); taps with r-K+1+i < 0 or c-K+1+j < 0 forced to 0 in out_win.
- Undefined: no masking logic; out_valid per interior rule above.

Test Plan:
- K=3, IMG_W=IMG_H=4, pixel=r*4+c+1, continuous in_valid, in_sof on first -> first out_valid after pixel 11 at (2,2), out_win={1,2,3,5,6,7,9,10,11}; exactly 4 windows; last {6,7,8,10,11,12,14,15,16} with frame_done=1.
- Same frame, in_valid alternating 1/0 -> identical window sequence; out_valid only on cycles after accepted pixels; outputs hold during gaps.
- Two back-to-back frames, second = first+100 -> second frame first window {101,102,103,105,106,107,109,110,111}; frame_done pulses twice.
- in_sof asserted at raster pixel (1,3) -> that pixel tagged (0,0); no out_valid until counter reaches (2,2).
- rst_n low mid-frame at (2,1) -> all outputs 0 asynchronously; next pixel after release tagged (0,0), no out_valid until (2,2).
- SLIDING_WIN_ZPAD_EN, same ramp -> 16 windows; (0,0) window only tap 8=1; (1,0) window tap 5=1, tap 8=5, others 0.
